trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_pkg.sv | 20 ++
 rtl/trace_fifo.sv | 49 ++++
 rtl/trace_capture.sv | 206 ++++++++++++++++++++
 tb/tb_trace_capture.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared encodings for the trace capture block: beat kinds on the trace
// output and the emitter state machine.
package trace_pkg;

    localparam int INST_W = 32;

    typedef enum logic [1:0] {
        KIND_PC   = 2'b00,
        KIND_INST = 2'b01,
        KIND_REG  = 2'b10
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_EMIT_PC   = 2'b01,
        ST_EMIT_INST = 2'b10,
        ST_EMIT_REG  = 2'b11
    } state_e;

endpackage

// File: rtl/trace_fifo.sv
// Commit-record FIFO with show-ahead read and wrap-around pointers that carry
// an extra MSB, so full and empty fall straight out of the pointer difference.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wptr_q;
    logic [PW:0]      rptr_q;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (doPush) wptr_q <= wptr_q + 1'b1;
            if (doPop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wptr_q[PW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[PW-1:0]];
    assign level_o = wptr_q - rptr_q;
    assign full_o  = level_o[PW];
    assign empty_o = (level_o == '0);

endmodule

// File: rtl/trace_capture.sv
// Non-blocking CPU commit tracer: buffers retired instructions and replays each
// as PC, INST and register beats against a shadow copy of the register file.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NREG      = 32,
    parameter int DEPTH     = 16,
    parameter int ZERO_HARD = 1
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      commit_valid,
    input  logic [DATA_W-1:0]         commit_pc,
    input  logic [INST_W-1:0]         commit_inst,
    input  logic                      commit_we,
    input  logic [$clog2(NREG)-1:0]   commit_waddr,
    input  logic [DATA_W-1:0]         commit_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_kind,
    output logic [$clog2(NREG)-1:0]   out_idx,
    output logic [DATA_W-1:0]         out_data,
    output logic [15:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int AW    = $clog2(NREG);
    localparam int REC_W = DATA_W + INST_W + 1 + AW + DATA_W;
    localparam logic [AW-1:0] ZERO_IDX = '0;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    logic [REC_W-1:0]  fifoWdata;
    logic [REC_W-1:0]  fifoRdata;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              pop;
    logic              drop;

    logic [DATA_W-1:0] fifoPc;
    logic [INST_W-1:0] fifoInst;
    logic              fifoWe;
    logic [AW-1:0]     fifoWaddr;
    logic [DATA_W-1:0] fifoWdata2;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [INST_W-1:0] recInst_q, recInst_d;
    logic              recWe_q, recWe_d;
    logic [AW-1:0]     recWaddr_q, recWaddr_d;
    logic [DATA_W-1:0] recWdata_q, recWdata_d;
    logic              outValid_q, outValid_d;
    kind_e             outKind_q, outKind_d;
    logic [AW-1:0]     outIdx_q, outIdx_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic [15:0]       dropCnt_q;
    logic [DATA_W-1:0] shadow_q [NREG];

    logic              fire;
    logic              advance;
    logic              deltaBeat;
    logic              shadowWe;
    logic [AW-1:0]     nextIdx;

    assign fifoWdata = {commit_pc, commit_inst, commit_we, commit_waddr, commit_wdata};
    assign {fifoPc, fifoInst, fifoWe, fifoWaddr, fifoWdata2} = fifoRdata;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (reset),
        .push_i  (commit_valid),
        .wdata_i (fifoWdata),
        .pop_i   (pop),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifo_level)
    );

    assign drop      = commit_valid && fifoFull && !pop;
    assign fire      = outValid_q && out_ready;
    assign nextIdx   = outIdx_q + 1'b1;
    assign deltaBeat = recWe_q && !((ZERO_HARD != 0) && (recWaddr_q == ZERO_IDX));
    // The shadow takes the record's write at pop time, ahead of any REG beat.
    assign shadowWe  = pop && fifoWe && !((ZERO_HARD != 0) && (fifoWaddr == ZERO_IDX));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            recInst_q  <= '0;
            recWe_q    <= 1'b0;
            recWaddr_q <= '0;
            recWdata_q <= '0;
            outValid_q <= 1'b0;
            outKind_q  <= KIND_PC;
            outIdx_q   <= '0;
            outData_q  <= '0;
            dropCnt_q  <= '0;
            for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            recInst_q  <= recInst_d;
            recWe_q    <= recWe_d;
            recWaddr_q <= recWaddr_d;
            recWdata_q <= recWdata_d;
            outValid_q <= outValid_d;
            outKind_q  <= outKind_d;
            outIdx_q   <= outIdx_d;
            outData_q  <= outData_d;
            if (drop && (dropCnt_q != 16'hFFFF)) dropCnt_q <= dropCnt_q + 16'd1;
            if (shadowWe) shadow_q[fifoWaddr] <= fifoWdata2;
        end
    end

    // Payload only moves on a handshake; finishing a record falls into the
    // shared "advance" path which either pops the next record or goes idle.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        recInst_d  = recInst_q;
        recWe_d    = recWe_q;
        recWaddr_d = recWaddr_q;
        recWdata_d = recWdata_q;
        outValid_d = outValid_q;
        outKind_d  = outKind_q;
        outIdx_d   = outIdx_q;
        outData_d  = outData_q;
        pop        = 1'b0;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE: advance = 1'b1;
            ST_EMIT_PC: begin
                if (fire) begin
                    state_d   = ST_EMIT_INST;
                    outKind_d = KIND_INST;
                    outIdx_d  = '0;
                    outData_d = DATA_W'(recInst_q);
                end
            end
            ST_EMIT_INST: begin
                if (fire) begin
                    if (mode_q) begin
                        state_d   = ST_EMIT_REG;
                        outKind_d = KIND_REG;
                        outIdx_d  = ZERO_IDX;
                        outData_d = shadow_q[ZERO_IDX];
                    end else if (deltaBeat) begin
                        state_d   = ST_EMIT_REG;
                        outKind_d = KIND_REG;
                        outIdx_d  = recWaddr_q;
                        outData_d = recWdata_q;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_EMIT_REG: begin
                if (fire) begin
                    if (mode_q && (outIdx_q != LAST_IDX)) begin
                        outIdx_d  = nextIdx;
                        outData_d = shadow_q[nextIdx];
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (!fifoEmpty) begin
                pop        = 1'b1;
                state_d    = ST_EMIT_PC;
                mode_d     = mode;
                recInst_d  = fifoInst;
                recWe_d    = fifoWe;
                recWaddr_d = fifoWaddr;
                recWdata_d = fifoWdata2;
                outValid_d = 1'b1;
                outKind_d  = KIND_PC;
                outIdx_d   = '0;
                outData_d  = fifoPc;
            end else begin
                state_d    = ST_IDLE;
                outValid_d = 1'b0;
                outKind_d  = KIND_PC;
                outIdx_d   = '0;
                outData_d  = '0;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_kind  = outKind_q;
    assign out_idx   = outIdx_q;
    assign out_data  = outData_q;
    assign drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: stimulus queues the expected beats, a
// negedge monitor compares every presented beat against the queue head.
module tb_trace_capture;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = 5;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              mode;
    logic              commit_valid;
    logic [DATA_W-1:0] commit_pc;
    logic [31:0]       commit_inst;
    logic              commit_we;
    logic [AW-1:0]     commit_waddr;
    logic [DATA_W-1:0] commit_wdata;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_kind;
    logic [AW-1:0]     out_idx;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       drop_cnt;
    logic [4:0]        fifo_level;

    typedef struct packed {
        logic [1:0]        kind;
        logic [AW-1:0]     idx;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             expQ[$];
    int                compared   = 0;
    int                mismatched = 0;
    logic [DATA_W-1:0] shadowModel [NREG];

    always #5 clk_in = ~clk_in;

    trace_capture #(
        .DATA_W    (DATA_W),
        .NREG      (NREG),
        .DEPTH     (DEPTH),
        .ZERO_HARD (1)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .mode         (mode),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .commit_we    (commit_we),
        .commit_waddr (commit_waddr),
        .commit_wdata (commit_wdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_kind     (out_kind),
        .out_idx      (out_idx),
        .out_data     (out_data),
        .drop_cnt     (drop_cnt),
        .fifo_level   (fifo_level)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic pushBeat(input logic [1:0] k, input logic [AW-1:0] i, input logic [DATA_W-1:0] d);
        beat_t b;
        b.kind = k;
        b.idx  = i;
        b.data = d;
        expQ.push_back(b);
    endtask

    task automatic pushDump();
        for (int i = 0; i < NREG; i++) pushBeat(2'b10, AW'(i), shadowModel[i]);
    endtask

    // Drives one commit for exactly one clock edge; called at posedge+1.
    task automatic applyStimulus(input logic m, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic we, input logic [AW-1:0] waddr, input logic [31:0] wdata);
        mode         = m;
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_inst  = inst;
        commit_we    = we;
        commit_waddr = waddr;
        commit_wdata = wdata;
        @(posedge clk_in);
        #1;
        commit_valid = 1'b0;
        commit_we    = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget, input bit toggle);
        int n = 0;
        while ((expQ.size() != 0 || out_valid) && n < budget) begin
            @(posedge clk_in);
            #1;
            if (toggle) out_ready = ~out_ready;
            n++;
        end
        out_ready = 1'b1;
        checkOutput(name, 64'(expQ.size() == 0 && !out_valid), 64'd1);
        expQ.delete();
    endtask

    // Monitor: every valid cycle is checked against the queue head, so a
    // stalled beat that changes payload is caught before it is accepted.
    always @(negedge clk_in) begin
        if (!reset && out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 64'({out_kind, out_idx, out_data}), 64'h7F_FFFF_FFFF);
            end else begin
                checkOutput("beat", 64'({out_kind, out_idx, out_data}), 64'(expQ[0]));
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        reset        = 1'b1;
        mode         = 1'b0;
        commit_valid = 1'b0;
        commit_pc    = '0;
        commit_inst  = '0;
        commit_we    = 1'b0;
        commit_waddr = '0;
        commit_wdata = '0;
        out_ready    = 1'b1;
        for (int i = 0; i < NREG; i++) shadowModel[i] = '0;

        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_kind", 64'(out_kind), 64'd0);
        checkOutput("reset_out_idx", 64'(out_idx), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        checkOutput("reset_fifo_level", 64'(fifo_level), 64'd0);
        reset = 1'b0;
        @(posedge clk_in);
        #1;

        $display("[TB] delta trace, single commit");
        pushBeat(2'b00, 5'd0, 32'h0040_0000);
        pushBeat(2'b01, 5'd0, 32'h2401_0005);
        pushBeat(2'b10, 5'd1, 32'd5);
        shadowModel[1] = 32'd5;
        applyStimulus(1'b0, 32'h0040_0000, 32'h2401_0005, 1'b1, 5'd1, 32'd5);
        checkOutput("latency_commit_edge_valid", 64'(out_valid), 64'd0);
        @(posedge clk_in);
        #1;
        checkOutput("latency_next_edge_valid", 64'(out_valid), 64'd1);
        waitDrain("delta_drain", 50, 1'b0);

        $display("[TB] full dump, single commit");
        pushBeat(2'b00, 5'd0, 32'h0040_0000);
        pushBeat(2'b01, 5'd0, 32'h2401_0005);
        pushDump();
        applyStimulus(1'b1, 32'h0040_0000, 32'h2401_0005, 1'b1, 5'd1, 32'd5);
        waitDrain("dump_drain", 100, 1'b0);

        $display("[TB] delta trace with toggling ready");
        pushBeat(2'b00, 5'd0, 32'h0040_0000);
        pushBeat(2'b01, 5'd0, 32'h2401_0005);
        pushBeat(2'b10, 5'd1, 32'd5);
        applyStimulus(1'b0, 32'h0040_0000, 32'h2401_0005, 1'b1, 5'd1, 32'd5);
        waitDrain("toggle_drain", 80, 1'b1);

        $display("[TB] overflow burst with sink stalled");
        // Record A is parked in the emitter first so the burst meets a busy
        // output and only the FIFO's 16 slots can absorb it.
        out_ready = 1'b0;
        pushBeat(2'b00, 5'd0, 32'h0000_3000);
        pushBeat(2'b01, 5'd0, 32'h0000_000A);
        applyStimulus(1'b0, 32'h0000_3000, 32'h0000_000A, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("burst_pre_level", 64'(fifo_level), 64'd0);
        for (int i = 0; i < 20; i++) begin
            if (i < 16) begin
                pushBeat(2'b00, 5'd0, 32'h2000 + 32'(4 * i));
                pushBeat(2'b01, 5'd0, 32'h1000_0000 + 32'(i));
                pushBeat(2'b10, 5'(2 + i % 4), 32'h100 + 32'(i));
                shadowModel[2 + i % 4] = 32'h100 + 32'(i);
            end
            applyStimulus(1'b0, 32'h2000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b1,
                          5'(2 + i % 4), 32'h100 + 32'(i));
        end
        checkOutput("burst_fifo_level", 64'(fifo_level), 64'd16);
        checkOutput("burst_drop_cnt", 64'(drop_cnt), 64'd4);
        out_ready = 1'b1;
        waitDrain("burst_drain", 200, 1'b0);

        $display("[TB] write to register zero");
        pushBeat(2'b00, 5'd0, 32'h0040_0010);
        pushBeat(2'b01, 5'd0, 32'h2400_FFFF);
        applyStimulus(1'b0, 32'h0040_0010, 32'h2400_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
        waitDrain("zero_delta_drain", 50, 1'b0);
        pushBeat(2'b00, 5'd0, 32'h0040_0014);
        pushBeat(2'b01, 5'd0, 32'h0000_0013);
        pushDump();
        applyStimulus(1'b1, 32'h0040_0014, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
        waitDrain("zero_dump_drain", 100, 1'b0);

        $display("[TB] reset during full dump");
        pushBeat(2'b00, 5'd0, 32'h0040_0020);
        pushBeat(2'b01, 5'd0, 32'h0000_0013);
        pushDump();
        applyStimulus(1'b1, 32'h0040_0020, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
        found = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk_in);
            #2;
            if (out_valid && out_kind == 2'b10 && out_idx == 5'd9) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reached_tenth_reg_beat", 64'(found), 64'd1);
        reset = 1'b1;
        expQ.delete();
        for (int i = 0; i < NREG; i++) shadowModel[i] = '0;
        @(posedge clk_in);
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_out_kind", 64'(out_kind), 64'd0);
        checkOutput("midreset_out_idx", 64'(out_idx), 64'd0);
        checkOutput("midreset_out_data", 64'(out_data), 64'd0);
        checkOutput("midreset_fifo_level", 64'(fifo_level), 64'd0);
        checkOutput("midreset_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk_in);
            #1;
            checkOutput("no_beat_after_release", 64'(out_valid), 64'd0);
        end
        pushBeat(2'b00, 5'd0, 32'h0040_0030);
        pushBeat(2'b01, 5'd0, 32'h0000_0013);
        pushDump();
        applyStimulus(1'b1, 32'h0040_0030, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
        waitDrain("post_reset_dump_drain", 100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
